huffman_decode: RTL
===================

HUFFMAN_DECODE -- requirements
Module: huffman_decode

Interface
REQ-001 The module SHALL have one clock and one asynchronous active-low reset; ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; when 0, all state returns to reset values immediately.
REQ-004 node_wr_en  in  1  write strobe for the tree-node table; honoured only when busy=0.
REQ-005 node_addr  in  8  node index, 0-255; root is node 0.
REQ-006 node_data  in  17  node word.
  - Leaf: bit16=1; [6:0]=character.
  - Internal: bit16=0; [15:8]=left child (bit 0); [7:0]=right child (bit 1).
REQ-007 start  in  1  single-cycle pulse; begins decoding a new stream.
REQ-008 clear  in  1  synchronous abort; has priority over start.
REQ-009 in_valid/in_ready  in/out  1/1  stream-word handshake; a transfer occurs on a cycle with both high.
REQ-010 in_data  in  32  encoded bits, consumed MSB (bit31) first.
REQ-011 in_last  in  1  marks the final word of the stream.
REQ-012 in_nbits  in  6  number of valid bits (1-32) in the last word; non-last words always carry 32 bits; value 0 is treated as 32.
REQ-013 out_valid/out_ready  out/in  1/1  decoded-symbol handshake.
REQ-014 out_char  out  7  decoded character.
REQ-015 busy, done, err  out  1 each  status flags.
REQ-016 sym_count  out  16  number of symbols emitted since the last start; saturates at 0xFFFF.

Function
REQ-017 The node table SHALL be 256x17 flops; a write lands on the clock edge where node_wr_en=1 and busy=0; reads SHALL be combinational.
REQ-018 The FSM SHALL have the states IDLE, LOAD, WALK, EMIT, DONE and ERR; busy=1 in LOAD, WALK and EMIT only.
REQ-019 In IDLE, DONE or ERR, start SHALL move the FSM to LOAD and clear ptr, the step counter, sym_count, done and err.
REQ-020 If node 0 is a leaf at start, the FSM SHALL go to ERR instead of LOAD.
REQ-021 LOAD: in_ready=1; on a transfer, the module SHALL latch the word; set the bit count to 32, or to in_nbits if in_last=1; latch in_last; then go to WALK.
REQ-022 in_ready SHALL be 0 in every state other than LOAD.
REQ-023 WALK SHALL consume exactly one bit per cycle:
  - nxt = left child of node[ptr] if the bit is 0, right child if it is 1.
  - The step counter increments.
REQ-024 In WALK, if node[nxt] is a leaf:
  - out_char <= node[nxt][6:0], out_valid <= 1;
  - ptr <= 0, step counter <= 0;
  - sym_count increments;
  - next state EMIT.
REQ-025 In WALK, if node[nxt] is internal, ptr <= nxt; when bits remain in the word the FSM stays in WALK.
REQ-026 In WALK, when the word is exhausted with ptr not equal to 0:
  - if the latched last flag is 0, go to LOAD with ptr kept (a code may span words);
  - if it is 1, go to ERR.
REQ-027 If the step counter reaches 255 without reaching a leaf (malformed or looping table), the FSM SHALL go to ERR.
REQ-028 EMIT SHALL hold out_valid and out_char stable until out_ready=1; on that cycle out_valid <= 0 and the next state is:
  - WALK if bits remain in the word;
  - else LOAD if last=0;
  - else DONE.
REQ-029 Latency:
  - The first bit is walked on the cycle after the word transfer.
  - out_valid rises on the cycle after the bit that completes the code.
  - Maximum throughput is one symbol per (code length + 1) cycles.
REQ-030 DONE SHALL assert done=1 and ERR SHALL assert err=1; both hold until the next start, clear or reset.
REQ-031 clear SHALL, from any state, on the next edge:
  - go to IDLE;
  - zero out_valid, ptr, the step counter, done and err;
  - leave the node table and sym_count unchanged.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 node_wr_en while busy=1 SHALL be ignored.

Reset
REQ-034 When reset=0, the module SHALL zero the state (IDLE), all node-table entries, ptr, the step counter, the word register, out_valid, out_char, in_ready, busy, done, err and sym_count.
REQ-035 The first edge after reset is released SHALL behave as a normal IDLE cycle.

Verification
REQ-036 The bench SHALL use a common tree for all scenarios:
  - node0 = {0,8'd1,8'd2}, node2 = {0,8'd3,8'd4};
  - node1 = leaf 0x41, node3 = leaf 0x42, node4 = leaf 0x43;
  - resulting codes: A=0, B=10, C=11.
REQ-037 Basic decode: in_data=32'h5800_0000, in_last=1, in_nbits=5, out_ready=1 -> out_char 0x41, 0x42, 0x43 in order; done=1; sym_count=3; err=0.
REQ-038 Backpressure: same stream with out_ready held 0 for 3 cycles at the first symbol -> out_valid=1 and out_char=0x41 held stable for those cycles; no symbol lost or duplicated.
REQ-039 Word-spanning code and in_ready gating:
  - Stimulus: word 32'h0000_0001 (last=0), then 32'h0000_0000 (last=1, nbits=1).
  - Response: 31 x 0x41 then one 0x42; sym_count=32; done=1.
  - in_ready=0 while walking each word.
REQ-040 Truncated stream: in_data=32'h8000_0000, in_last=1, in_nbits=1 -> err=1, no symbol emitted, sym_count=0.
REQ-041 Abort and reset:
  - clear asserted mid-WALK -> IDLE next edge, out_valid=0, node table intact; a following restart decodes REQ-037 correctly.
  - reset pulled low mid-EMIT -> out_valid=0 immediately; all node entries read 0.
  - start on an all-zero table -> err=1.

Source files
------------

// File: rtl/huffman_decode.sv
// Huffman bit-stream decoder: walks a 256-entry binary tree one input bit per
// cycle and emits a 7-bit character through a valid/ready handshake per leaf.
module huffman_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        node_wr_en,
    input  logic [7:0]  node_addr,
    input  logic [16:0] node_data,
    input  logic        start,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [5:0]  in_nbits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_char,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] sym_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WALK, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [16:0] node_mem [256];
    logic [7:0]  ptr_reg;
    logic [7:0]  step_reg;
    logic [31:0] word_reg;
    logic [5:0]  bits_reg;
    logic        last_reg;
    logic        out_valid_reg;
    logic [6:0]  out_char_reg;
    logic [15:0] sym_count_reg;

    logic [7:0]  nxt;
    logic        leaf_hit;
    logic [7:0]  step_inc;
    logic        limit_hit;
    logic        word_end;
    logic        root_leaf;
    logic [5:0]  load_bits;

    // Bit 0 selects the left child in [15:8], bit 1 the right child in [7:0].
    assign nxt       = word_reg[31] ? node_mem[ptr_reg][7:0] : node_mem[ptr_reg][15:8];
    assign leaf_hit  = node_mem[nxt][16];
    assign step_inc  = step_reg + 8'd1;
    assign limit_hit = (step_inc == 8'hFF);
    assign word_end  = (bits_reg == 6'd1);
    assign root_leaf = node_mem[0][16];
    assign load_bits = (in_last && (in_nbits != 6'd0) && (in_nbits <= 6'd32)) ? in_nbits : 6'd32;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_next = root_leaf ? S_ERR : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        state_next = S_WALK;
                    end
                end
                S_WALK: begin
                    // Running out of bits without a leaf always means a partial code.
                    if (leaf_hit) begin
                        state_next = S_EMIT;
                    end else if (limit_hit) begin
                        state_next = S_ERR;
                    end else if (word_end) begin
                        state_next = last_reg ? S_ERR : S_LOAD;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (bits_reg != 6'd0) begin
                            state_next = S_WALK;
                        end else begin
                            state_next = last_reg ? S_DONE : S_LOAD;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_reg == S_LOAD);
        busy     = (state_reg == S_LOAD) || (state_reg == S_WALK) || (state_reg == S_EMIT);
        done     = (state_reg == S_DONE);
        err      = (state_reg == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                node_mem[i] <= '0;
            end
        end else if (node_wr_en && !busy) begin
            node_mem[node_addr] <= node_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg       <= '0;
            step_reg      <= '0;
            word_reg      <= '0;
            bits_reg      <= '0;
            last_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_char_reg  <= '0;
            sym_count_reg <= '0;
        end else if (clear) begin
            ptr_reg       <= '0;
            step_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        ptr_reg       <= '0;
                        step_reg      <= '0;
                        sym_count_reg <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        word_reg <= in_data;
                        bits_reg <= load_bits;
                        last_reg <= in_last;
                    end
                end
                S_WALK: begin
                    word_reg <= {word_reg[30:0], 1'b0};
                    bits_reg <= bits_reg - 6'd1;
                    if (leaf_hit) begin
                        out_char_reg  <= node_mem[nxt][6:0];
                        out_valid_reg <= 1'b1;
                        ptr_reg       <= '0;
                        step_reg      <= '0;
                        if (sym_count_reg != 16'hFFFF) begin
                            sym_count_reg <= sym_count_reg + 16'd1;
                        end
                    end else begin
                        ptr_reg  <= nxt;
                        step_reg <= step_inc;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_char  = out_char_reg;
    assign sym_count = sym_count_reg;

endmodule
